// File: rtl/pipe_pkg.sv
// Shared constants and event encoding for the pipeline hazard controller.
package pipe_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Hazard events, listed lowest to highest priority.
    typedef enum logic [2:0] {
        EV_NONE,
        EV_JUMP,
        EV_LOAD_USE,
        EV_MULDIV,
        EV_JR,
        EV_BRANCH,
        EV_RESET
    } hazard_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with a synchronous active-low clear.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             clr_ni,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for a 5-stage pipeline, with load-use
// interlock, multi-cycle mul/div occupancy and saturating event counters.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW        = 5,
    parameter int unsigned MULDIV_LAT    = 4,
    parameter int unsigned BRANCH_IN_MEM = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_is_muldiv,
    input  logic              id_jump,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic              ex_jr,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_regwrite,
    input  logic              wb_regwrite,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              muldiv_busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned BUSY_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(MULDIV_LAT - 1);
    localparam logic BRANCH_FLUSHES_EX = (BRANCH_IN_MEM != 0);

    logic [BUSY_W-1:0] busy_q, busy_d;
    logic              busy;
    logic              load_use;
    logic              muldiv_issue;
    hazard_e           ev;

    // The younger producer (MEM) must win over the older one (WB).
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              m_we,
        input logic [REG_AW-1:0] m_rd,
        input logic              w_we,
        input logic [REG_AW-1:0] w_rd
    );
        if (m_we && (m_rd != '0) && (m_rd == src)) begin
            return FWD_MEM;
        end else if (w_we && (w_rd != '0) && (w_rd == src)) begin
            return FWD_WB;
        end
        return FWD_REGFILE;
    endfunction

    assign busy = (busy_q != '0);

    always_comb begin
        load_use = ex_memread && ex_regwrite && (ex_rd != '0) &&
                   ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

        if (!Reset)            ev = EV_RESET;
        else if (branch_taken) ev = EV_BRANCH;
        else if (ex_jr)        ev = EV_JR;
        else if (busy)         ev = EV_MULDIV;
        else if (load_use)     ev = EV_LOAD_USE;
        else if (id_jump)      ev = EV_JUMP;
        else                   ev = EV_NONE;
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        fwd_a        = fwd_sel(ex_rs, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
        fwd_b        = fwd_sel(ex_rt, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
        muldiv_busy  = busy;

        unique case (ev)
            EV_RESET: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                fwd_a        = FWD_REGFILE;
                fwd_b        = FWD_REGFILE;
                muldiv_busy  = 1'b0;
            end
            EV_BRANCH: begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = BRANCH_FLUSHES_EX;
            end
            EV_JR: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
            EV_MULDIV: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_flush = 1'b1;
            end
            EV_LOAD_USE: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
            EV_JUMP: begin
                if_id_flush = 1'b1;
            end
            default: ;
        endcase
    end

    // A mul/div only occupies EX once it actually leaves ID (not held, not bubbled).
    assign muldiv_issue = id_is_muldiv && id_ex_write && !id_ex_flush;

    always_comb begin
        busy_d = busy_q;
        if (branch_taken) begin
            busy_d = '0;
        end else if (muldiv_issue) begin
            busy_d = BUSY_LOAD;
        end else if (busy) begin
            busy_d = busy_q - BUSY_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i  (Clk),
        .clr_ni (Reset),
        .inc_i  (!pc_write),
        .cnt_o  (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk_i  (Clk),
        .clr_ni (Reset),
        .inc_i  (if_id_flush || id_ex_flush || ex_mem_flush),
        .cnt_o  (flush_cnt)
    );

endmodule
